// File: rtl/dmem_responder.sv
// Word-addressed data memory responder with a fixed number of wait states.
// A request is captured in IDLE, held for WAIT_CYCLES cycles, and answered
// with a one-cycle ready strobe. Misaligned or out-of-range accesses report
// err and never touch storage. Writes commit at the edge that ends RESP.
module dmem_responder #(
  parameter int AW_WORDS    = 6,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        we,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic [3:0]  be,
  output logic        ready,
  output logic [31:0] rdata,
  output logic        err
);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  // WAIT is left on the cycle the counter reads zero, so it starts one below
  // the wait-state count.
  localparam logic [3:0] CNT_INIT = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

  state_t              state, state_nx;
  logic [3:0]          cnt, cnt_nx;
  logic                cap;
  logic                we_q;
  logic [31:0]         addr_q, wdata_q;
  logic [3:0]          be_q;
  logic                bad;
  logic [AW_WORDS-1:0] idx;
  logic [31:0]         mem [2**AW_WORDS];

  assign idx = addr_q[AW_WORDS+1:2];
  assign bad = (addr_q[1:0] != 2'b00) || ((addr_q >> (AW_WORDS + 2)) != 32'd0);

  // Next-state, counter and response outputs; outputs are zero outside RESP.
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    cap      = 1'b0;
    ready    = 1'b0;
    err      = 1'b0;
    rdata    = 32'd0;
    case (state)
      IDLE: begin
        if (req) begin
          cap = 1'b1;
          if (WAIT_CYCLES == 0) begin
            state_nx = RESP;
          end else begin
            state_nx = WAIT;
            cnt_nx   = CNT_INIT;
          end
        end
      end
      WAIT: begin
        if (cnt == 4'd0) state_nx = RESP;
        else             cnt_nx   = cnt - 4'd1;
      end
      RESP: begin
        ready    = 1'b1;
        err      = bad;
        rdata    = (!bad && !we_q) ? mem[idx] : 32'd0;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // State, counter and captured request; reset drops any pending transaction.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      cnt     <= 4'd0;
      we_q    <= 1'b0;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
      be_q    <= 4'd0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      if (cap) begin
        we_q    <= we;
        addr_q  <= addr;
        wdata_q <= wdata;
        be_q    <= be;
      end
    end
  end

  // Byte-masked write at the end of RESP. Storage has no reset; an async
  // reset forces state to IDLE, which also blocks a pending write.
  always_ff @(posedge clk) begin
    if (state == RESP && we_q && !bad) begin
      for (int i = 0; i < 4; i++) begin
        if (be_q[i]) mem[idx][8*i +: 8] <= wdata_q[8*i +: 8];
      end
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Randomized scoreboard bench for dmem_responder: stimulus pushes expected
// responses, an independent monitor pops them whenever ready is seen.
module tb_dmem_responder;
  localparam int W = 2;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic        req, we, ready, err;
  logic [31:0] addr, wdata, rdata;
  logic [3:0]  be;
  logic        req0, we0, ready0, err0;
  logic [31:0] addr0, wdata0, rdata0;
  logic [3:0]  be0;

  dmem_responder #(.AW_WORDS(6), .WAIT_CYCLES(W)) dut (
    .clk(clk), .reset(reset), .req(req), .we(we), .addr(addr), .wdata(wdata),
    .be(be), .ready(ready), .rdata(rdata), .err(err));

  dmem_responder #(.AW_WORDS(6), .WAIT_CYCLES(0)) dut0 (
    .clk(clk), .reset(reset), .req(req0), .we(we0), .addr(addr0), .wdata(wdata0),
    .be(be0), .ready(ready0), .rdata(rdata0), .err(err0));

  int errors = 0;
  int checks = 0;
  int edge_cnt = 0;
  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  typedef struct {
    logic [31:0] rd;
    logic [31:0] mask;
    logic        er;
    int          exp_edge;
  } exp_t;
  exp_t sbq[$];

  // Reference memory: word contents plus a per-bit "known" mask, since the
  // DUT storage starts undefined.
  logic [31:0] mdl   [64];
  logic [31:0] known [64];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got %h want %h (edge %0d)", nm, act, want, edge_cnt);
    end
  endtask

  // Monitor: every response must match the head of the scoreboard in
  // timing, err and rdata; between responses all outputs must be zero.
  exp_t e;
  always @(negedge clk) begin
    if (ready === 1'b1) begin
      if (sbq.size() == 0) chk("unexpected_ready", 32'd1, 32'd0);
      else begin
        e = sbq.pop_front();
        chk("latency", edge_cnt, e.exp_edge);
        chk("err", {31'd0, err}, {31'd0, e.er});
        chk("rdata", rdata & e.mask, e.rd & e.mask);
      end
    end else begin
      chk("idle_ready", {31'd0, ready}, 32'd0);
      chk("idle_err", {31'd0, err}, 32'd0);
      chk("idle_rdata", rdata, 32'd0);
      if (sbq.size() > 0 && edge_cnt > sbq[0].exp_edge) begin
        chk("timeout", 32'd0, 32'd1);
        sbq.delete(0);
      end
    end
  end

  // One transaction. rst_at >= 0 pulses reset that many cycles after
  // capture and expects no response and no storage change.
  task automatic txn(input logic w, input logic [31:0] a, input logic [31:0] d,
                     input logic [3:0] b, input bit hold, input int rst_at);
    int   m;
    bit   bad;
    exp_t x;
    @(negedge clk);
    req = 1'b1; we = w; addr = a; wdata = d; be = b;
    m   = edge_cnt;
    bad = (a[1:0] != 2'b00) || (a >= 32'd256);
    if (rst_at < 0) begin
      x.exp_edge = m + 1 + W;
      x.er       = bad;
      if (bad || w) begin
        x.rd = 32'd0; x.mask = '1;
      end else begin
        x.rd = mdl[a[7:2]]; x.mask = known[a[7:2]];
      end
      sbq.push_back(x);
      if (w && !bad)
        for (int i = 0; i < 4; i++)
          if (b[i]) begin
            mdl[a[7:2]][8*i +: 8]   = d[8*i +: 8];
            known[a[7:2]][8*i +: 8] = 8'hff;
          end
    end
    for (int k = 0; k < W + 2; k++) begin
      @(posedge clk);
      #1;
      req = hold; we = 1'($urandom); addr = $urandom; wdata = $urandom; be = 4'($urandom);
      if (k == rst_at) begin
        req = 1'b0; reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        break;
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int m;
    logic [31:0] a;
    for (int i = 0; i < 64; i++) begin mdl[i] = 32'd0; known[i] = 32'd0; end
    reset = 1'b1;
    req = 0; we = 0; addr = 0; wdata = 0; be = 0;
    req0 = 0; we0 = 0; addr0 = 0; wdata0 = 0; be0 = 0;
    repeat (2) @(negedge clk);
    chk("reset_ready0", {31'd0, ready0}, 32'd0);
    chk("reset_err0", {31'd0, err0}, 32'd0);
    chk("reset_rdata0", rdata0, 32'd0);
    reset = 1'b0;

    // Directed: full write/read, byte merge, errors, be=0, holds.
    txn(1, 32'h10, 32'hDEADBEEF, 4'hf, 0, -1);
    txn(0, 32'h10, 32'h0, 4'h0, 0, -1);
    txn(1, 32'h10, 32'h00001234, 4'h3, 0, -1);
    txn(0, 32'h10, 32'h0, 4'h0, 1, -1);
    txn(0, 32'h13, 32'h0, 4'h0, 0, -1);
    txn(0, 32'h100, 32'h0, 4'h0, 0, -1);
    txn(1, 32'h100, 32'h55555555, 4'hf, 0, -1);
    txn(0, 32'h10, 32'h0, 4'h0, 0, -1);
    txn(1, 32'h14, 32'hAAAA5555, 4'hf, 1, -1);
    txn(1, 32'h14, 32'h12345678, 4'h0, 0, -1);
    txn(0, 32'h14, 32'h0, 4'h0, 1, -1);

    // Reset during WAIT and during RESP discards a pending write.
    txn(1, 32'h20, 32'h11112222, 4'hf, 0, -1);
    txn(1, 32'h20, 32'hCAFEF00D, 4'hf, 0, 0);
    txn(0, 32'h20, 32'h0, 4'h0, 1, -1);
    txn(1, 32'h24, 32'h01020304, 4'hf, 0, -1);
    txn(1, 32'h24, 32'hFFFFFFFF, 4'hf, 0, W);
    txn(0, 32'h24, 32'h0, 4'h0, 0, -1);

    // Randomized traffic, mostly valid word addresses.
    for (int n = 0; n < 200; n++) begin
      case ($urandom_range(0, 9))
        0:       a = $urandom;
        1:       a = {24'd0, 6'($urandom), 2'($urandom_range(1, 3))};
        default: a = {24'd0, 6'($urandom), 2'b00};
      endcase
      txn(1'($urandom), a, $urandom, 4'($urandom), 1'($urandom), -1);
    end
    req = 1'b0;
    repeat (W + 4) @(negedge clk);
    chk("queue_drained", sbq.size(), 32'd0);

    // Zero wait states, req held: a response every second cycle.
    req0 = 1'b1; we0 = 1'b0; addr0 = 32'h13;
    m = edge_cnt;
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      chk("w0_ready", {31'd0, ready0}, {31'd0, ((edge_cnt - m) % 2) == 1});
      chk("w0_err", {31'd0, err0}, {31'd0, ((edge_cnt - m) % 2) == 1});
      chk("w0_rdata", rdata0, 32'd0);
    end
    req0 = 1'b0;
    repeat (3) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
